// File: rtl/guarded_state_fsm.sv
//------------------------------------------------------------------------------
// guarded_state_fsm
//
// Purpose:
//   Hardened committed-state register that sits between untrusted control
//   inputs and downstream decode logic. A requester proposes a next state over
//   a valid/ready handshake. Only legal encodings (0..NUM_STATES-1) are
//   committed. Illegal proposals are rejected, flagged and counted, and a run
//   of ERR_LIMIT consecutive illegal proposals forces the safe state (0) and
//   locks the block until an explicit unlock. A minimum dwell time between
//   handshakes rate-limits transitions. A corrupted committed state (for
//   example after an upset) is detected and returned to the safe state.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   req_valid  in   request present (held with req_state until req_ready)
//   req_state  in   proposed next state, STATE_W bits
//   unlock     in   single-cycle release from lockout
//   req_ready  out  request accepted this cycle when req_valid is high
//   out        out  current committed state (registered), STATE_W bits
//   req_err    out  one-cycle pulse: rejected request or corrupted state
//   locked     out  lockout active
//   err_count  out  consecutive illegal-request count, CNT_W bits
//
// Parameter constraints:
//   1 <= NUM_STATES <= 2**STATE_W, ERR_LIMIT >= 1, DWELL >= 1.
//------------------------------------------------------------------------------
module guarded_state_fsm #(
    parameter int unsigned STATE_W    = 3,
    parameter int unsigned NUM_STATES = 6,
    parameter int unsigned ERR_LIMIT  = 3,
    parameter int unsigned DWELL      = 2,
    parameter int unsigned CNT_W      = $clog2(ERR_LIMIT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [STATE_W-1:0] req_state,
    input  logic               unlock,
    output logic               req_ready,
    output logic [STATE_W-1:0] out,
    output logic               req_err,
    output logic               locked,
    output logic [CNT_W-1:0]   err_count
);

    localparam int unsigned DW_W = $clog2(DWELL + 1);

    localparam logic [STATE_W-1:0] SAFE_STATE = '0;
    localparam logic [DW_W-1:0]    DWELL_MAX  = DW_W'(DWELL);
    localparam logic [CNT_W-1:0]   ERR_MAX    = CNT_W'(ERR_LIMIT);

    // When every encoding is legal, rejection and corruption paths are dead
    // and the legality check folds to a constant.
    localparam bit HAS_ILLEGAL = (NUM_STATES < (2 ** STATE_W));

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    logic [STATE_W-1:0] out_q,     out_d;
    logic               req_err_q, req_err_d;
    logic               locked_q,  locked_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [DW_W-1:0]    dwell_q,   dwell_d;

    logic               fire;
    logic               corrupt;
    logic               req_legal;
    logic [CNT_W-1:0]   err_inc;
    logic [DW_W-1:0]    dwell_step;

    function automatic logic is_legal(input logic [STATE_W-1:0] s);
        if (!HAS_ILLEGAL) begin
            return 1'b1;
        end
        return (32'(s) < NUM_STATES);
    endfunction

    //--------------------------------------------------------------------------
    // Handshake and classification
    //--------------------------------------------------------------------------
    assign req_ready  = !locked_q && (dwell_q == DWELL_MAX);
    assign fire       = req_valid && req_ready;
    assign corrupt    = !is_legal(out_q);
    assign req_legal  = is_legal(req_state);

    // err_cnt_q is always below ERR_LIMIT when a new illegal request can
    // arrive (reaching the limit locks the block), so this cannot overflow.
    assign err_inc    = err_cnt_q + CNT_W'(1);

    // Dwell counter saturates at DWELL; req_ready is derived from saturation.
    assign dwell_step = (dwell_q == DWELL_MAX) ? dwell_q : (dwell_q + DW_W'(1));

    //--------------------------------------------------------------------------
    // Next-state logic
    //   Priority: corrupted state > lockout > handshake.
    //   A handshake coinciding with a corrupted state is discarded and does
    //   not restart the dwell window.
    //--------------------------------------------------------------------------
    always_comb begin
        out_d     = out_q;
        req_err_d = 1'b0;
        locked_d  = locked_q;
        err_cnt_d = err_cnt_q;
        dwell_d   = dwell_step;

        if (corrupt) begin
            out_d     = SAFE_STATE;
            req_err_d = 1'b1;
        end else if (locked_q) begin
            out_d = SAFE_STATE;
            if (unlock) begin
                locked_d  = 1'b0;
                err_cnt_d = '0;
                dwell_d   = DWELL_MAX;
            end
        end else if (fire) begin
            dwell_d = '0;
            if (req_legal) begin
                out_d     = req_state;
                err_cnt_d = '0;
            end else begin
                req_err_d = 1'b1;
                if (err_inc == ERR_MAX) begin
                    locked_d  = 1'b1;
                    out_d     = SAFE_STATE;
                    err_cnt_d = ERR_MAX;
                end else begin
                    err_cnt_d = err_inc;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Registers (synchronous active-low reset overrides everything)
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= SAFE_STATE;
            req_err_q <= 1'b0;
            locked_q  <= 1'b0;
            err_cnt_q <= '0;
            dwell_q   <= DWELL_MAX;
        end else begin
            out_q     <= out_d;
            req_err_q <= req_err_d;
            locked_q  <= locked_d;
            err_cnt_q <= err_cnt_d;
            dwell_q   <= dwell_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign out       = out_q;
    assign req_err   = req_err_q;
    assign locked    = locked_q;
    assign err_count = err_cnt_q;

endmodule
